// File: rtl/data_seq_pkg.sv
// rtl/data_seq_pkg.sv - state encoding shared by the sequence checker
package data_seq_pkg;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that holds at all-ones; clear beats increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/data_seq_check.sv
// rtl/data_seq_check.sv - frame checker for the incrementing test-pattern generator
module data_seq_check
    import data_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIRST_VAL   = 1,
    parameter int SEQ_LEN     = 10,
    parameter int GAP_LEN     = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              cnt_clr,
    output logic              locked,
    output logic              frame_done,
    output logic              err_pulse,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W  = $clog2(SEQ_LEN);
    localparam int GCNT_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int RUN_W  = $clog2(LOCK_FRAMES + 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [GCNT_W-1:0] gcnt;
    logic [RUN_W-1:0]  good_run;

    logic [DATA_W-1:0] exp_val;
    logic              is_first;
    logic              match;
    logic              last;
    logic              in_check;
    logic              good_frame;
    logic              bad_sample;
    logic [RUN_W-1:0]  run_next;

    // Expected value wraps modulo 2^DATA_W by construction of the addition width.
    assign exp_val    = DATA_W'(FIRST_VAL) + DATA_W'(idx);
    assign is_first   = (data_in == DATA_W'(FIRST_VAL));
    assign match      = (data_in == exp_val);
    assign last       = (idx == IDX_W'(SEQ_LEN - 1));
    assign in_check   = data_valid && (state == ST_CHECK);
    assign good_frame = in_check && match && last;
    assign bad_sample = in_check && !match;
    assign run_next   = (good_run == RUN_W'(LOCK_FRAMES)) ? good_run : good_run + 1'b1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_HUNT;
            idx        <= '0;
            gcnt       <= '0;
            good_run   <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
            err_data   <= '0;
        end else begin
            frame_done <= good_frame;
            err_pulse  <= bad_sample;
            if (data_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (is_first) begin
                            state <= ST_CHECK;
                            idx   <= IDX_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (match) begin
                            if (last) begin
                                good_run <= run_next;
                                locked   <= (run_next == RUN_W'(LOCK_FRAMES));
                                idx      <= '0;
                                gcnt     <= '0;
                                if (GAP_LEN != 0) begin
                                    state <= ST_GAP;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            err_data <= data_in;
                            good_run <= '0;
                            locked   <= 1'b0;
                            // A mismatching FIRST_VAL is taken as the start of a new frame.
                            if (is_first) begin
                                idx <= IDX_W'(1);
                            end else begin
                                state <= ST_HUNT;
                                idx   <= '0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gcnt == GCNT_W'(GAP_LEN - 1)) begin
                            state <= ST_CHECK;
                            idx   <= '0;
                            gcnt  <= '0;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_HUNT;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (cnt_clr),
        .inc     (good_frame),
        .q       (frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (cnt_clr),
        .inc     (bad_sample),
        .q       (err_cnt)
    );

endmodule

// File: tb/tb_data_seq_check.sv
// tb/tb_data_seq_check.sv - scoreboard bench for data_seq_check
module tb_data_seq_check;

    localparam int CW = 4;

    logic          sys_clk;
    logic          sys_rst;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          cnt_clr;
    logic          locked;
    logic          frame_done;
    logic          err_pulse;
    logic [7:0]    err_data;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;
    int   act_kind;

    data_seq_check #(.CNT_W(CW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .cnt_clr    (cnt_clr),
        .locked     (locked),
        .frame_done (frame_done),
        .err_pulse  (err_pulse),
        .err_data   (err_data),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // kind 1 = frame_done, kind 2 = err_pulse carrying err_data
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                tests++;
                failed++;
                $display("FAIL missed_pulse: kind %0d due at cycle %0d, still absent at cycle %0d",
                         sb_q[0].kind, sb_q[0].cyc, cyc);
                void'(sb_q.pop_front());
            end
            if (frame_done || err_pulse) begin
                act_kind = {30'd0, err_pulse, frame_done};
                tests++;
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", act_kind, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.kind != act_kind ||
                        (mon_e.kind == 2 && err_data !== mon_e.d)) begin
                        failed++;
                        $display("FAIL pulse: got kind %0d cycle %0d err_data %0h, expected kind %0d cycle %0d err_data %0h",
                                 act_kind, cyc, err_data, mon_e.kind, mon_e.cyc, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic v, input int ev, input logic c);
        @(negedge sys_clk);
        data_in    = d;
        data_valid = v;
        cnt_clr    = c;
        if (ev != 0) sb_q.push_back('{cyc + 1, ev, d});
    endtask

    task automatic settle();
        @(negedge sys_clk);
        data_valid = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] d);
        @(negedge sys_clk);
        sys_rst    = 1'b1;
        data_in    = d;
        data_valid = 1'b1;
        cnt_clr    = 1'b0;
        sb_q.delete();
        @(negedge sys_clk);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_data", 32'(err_data), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        sys_rst    = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic frame(input logic clr_at_end, input logic toggle);
        for (int v = 1; v <= 10; v++) begin
            send(8'(v), 1'b1, (v == 10) ? 1 : 0, clr_at_end && (v == 10));
            if (toggle) send(8'hEE, 1'b0, 0, 1'b0);
        end
        send(8'h55, 1'b1, 0, 1'b0);
        if (toggle) send(8'hEE, 1'b0, 0, 1'b0);
    endtask

    initial begin
        sys_rst    = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        cnt_clr    = 1'b0;
        repeat (2) @(posedge sys_clk);

        // 1: three clean frames
        do_reset(8'h00);
        frame(0, 0);
        settle();
        chk("t1_locked_after_1", 32'(locked), 0);
        frame(0, 0);
        settle();
        chk("t1_locked_after_2", 32'(locked), 1);
        frame(0, 0);
        settle();
        chk("t1_frame_cnt", 32'(frame_cnt), 3);
        chk("t1_err_cnt", 32'(err_cnt), 0);

        // 2: junk while hunting is not an error
        do_reset(8'h00);
        repeat (5) send(8'hAA, 1'b1, 0, 1'b0);
        frame(0, 0);
        settle();
        chk("t2_frame_cnt", 32'(frame_cnt), 1);
        chk("t2_err_cnt", 32'(err_cnt), 0);

        // 3: mid-frame mismatch drops lock, then relock
        do_reset(8'h00);
        frame(0, 0);
        frame(0, 0);
        send(8'd1, 1'b1, 0, 1'b0);
        send(8'd2, 1'b1, 0, 1'b0);
        send(8'd3, 1'b1, 0, 1'b0);
        send(8'd7, 1'b1, 2, 1'b0);
        for (int v = 8; v <= 10; v++) send(8'(v), 1'b1, 0, 1'b0);
        send(8'h55, 1'b1, 0, 1'b0);
        settle();
        chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_err_data", 32'(err_data), 7);
        chk("t3_locked", 32'(locked), 0);
        chk("t3_frame_cnt", 32'(frame_cnt), 2);
        frame(0, 0);
        frame(0, 0);
        settle();
        chk("t3_relock", 32'(locked), 1);
        chk("t3_frame_cnt2", 32'(frame_cnt), 4);

        // 4: resync on a premature FIRST_VAL
        do_reset(8'h00);
        frame(0, 0);
        frame(0, 0);
        send(8'd1, 1'b1, 0, 1'b0);
        send(8'd2, 1'b1, 0, 1'b0);
        send(8'd1, 1'b1, 2, 1'b0);
        for (int v = 2; v <= 10; v++) send(8'(v), 1'b1, (v == 10) ? 1 : 0, 1'b0);
        send(8'h55, 1'b1, 0, 1'b0);
        settle();
        chk("t4_err_cnt", 32'(err_cnt), 1);
        chk("t4_err_data", 32'(err_data), 1);
        chk("t4_frame_cnt", 32'(frame_cnt), 3);
        chk("t4_locked", 32'(locked), 0);
        frame(0, 0);
        settle();
        chk("t4_relock", 32'(locked), 1);

        // 5: data_valid toggling every cycle
        do_reset(8'h00);
        frame(0, 1);
        frame(0, 1);
        settle();
        chk("t5_frame_cnt", 32'(frame_cnt), 2);
        chk("t5_err_cnt", 32'(err_cnt), 0);
        chk("t5_locked", 32'(locked), 1);

        // 6: saturation, clear beating increment, reset mid-frame
        do_reset(8'h00);
        repeat (20) frame(0, 0);
        settle();
        chk("t6_frame_cnt_sat", 32'(frame_cnt), 15);
        frame(1, 0);
        settle();
        chk("t6_clr_wins", 32'(frame_cnt), 0);
        chk("t6_locked_pre_rst", 32'(locked), 1);
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b1, 0, 1'b0);
        do_reset(8'd5);
        for (int v = 6; v <= 10; v++) send(8'(v), 1'b1, 0, 1'b0);
        send(8'h55, 1'b1, 0, 1'b0);
        settle();
        settle();
        chk("t6_partial_frame_cnt", 32'(frame_cnt), 0);
        chk("t6_partial_err_cnt", 32'(err_cnt), 0);
        chk("t6_partial_locked", 32'(locked), 0);

        settle();
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
